sc_lane_shifter: RTL and testbench
==================================

Name: sc_lane_shifter

Overview:
- Downstream consumer of the speed comparator's active-low tick (counter == speed threshold → tick low).
- Holds one Frogger lane pattern (cars/logs) in a rotating register and advances it one cell per tick falling edge.
- Output feeds the lane-to-matrix display mux and the collision checker.
- Supports runtime pattern load, direction select and pause. Tick generation stays upstream.

Parameters:
- LANESHIFTER_DATAWIDTH, 8, lane width in cells.
- LANESHIFTER_INIT, 8'b00110011, pattern loaded on reset; width = DATAWIDTH.

Ports:
- SC_LANESHIFTER_CLOCK_50  in  1  system clock, 50 MHz.
- SC_LANESHIFTER_RESET_InHigh  in  1  synchronous, active-high reset.
- SC_LANESHIFTER_tick_InLow  in  1  speed tick from comparator, active low, may stay low for more than one cycle.
- SC_LANESHIFTER_load_InLow  in  1  synchronous load strobe, active low.
- SC_LANESHIFTER_data_InBUS  in  DATAWIDTH  pattern captured on load.
- SC_LANESHIFTER_dir_InHigh  in  1  1 = rotate right (MSB→LSB), 0 = rotate left.
- SC_LANESHIFTER_pause_InHigh  in  1  freezes motion while high.
- SC_LANESHIFTER_data_OutBUS  out  DATAWIDTH  current lane pattern, registered.
- SC_LANESHIFTER_step_OutHigh  out  1  one-cycle pulse in the cycle after each rotate.

Behaviour:
- One clock domain. Reset is synchronous, active-high, and dominates all other inputs.
- Reset values:
  - data_OutBUS = LANESHIFTER_INIT
  - step_OutHigh = 0
  - tick_d (tick history register) = 0
  - state = ST_IDLE
- Edge detect: tick_fall = tick_d & ~tick_InLow; tick_d <= tick_InLow every non-reset cycle.
  - Reset value 0 means a tick held low through reset exit is not an edge.
  - A tick held low for N cycles yields exactly one fall.
- FSM states: ST_IDLE, ST_RUN, ST_HOLD.
  - ST_IDLE: no motion. load_InLow = 0 → capture data_InBUS, go to ST_RUN. tick_fall is ignored.
  - ST_RUN: on tick_fall, rotate once in dir_InHigh direction. pause = 1 → ST_HOLD.
  - ST_HOLD: no motion; tick_fall is dropped, not queued. pause = 0 → ST_RUN. Load is still accepted in this state and the state stays ST_HOLD.
- Rotate rules:
  - Left: {d[W-2:0], d[W-1]}.
  - Right: {d[0], d[W-1:1]}.
  - Pure rotate: popcount is preserved, no bits are injected.
- Latency: fall sampled at clock edge n → data_OutBUS updated at edge n+1 (one register stage after tick_d). step_OutHigh is high in the same cycle the new value first appears, then low.
- Priority within a cycle: reset > load > pause > tick_fall.
  - Load and tick_fall together: load wins; that tick is discarded and step stays 0.
  - Load in ST_RUN: new pattern appears next cycle; state stays ST_RUN.
- dir_InHigh is sampled only in the cycle the rotate is applied. Changing it mid-run affects the next step only.
- Reset mid-run or mid-hold: next cycle shows INIT, ST_IDLE, step 0. Any pending edge is lost.
- Degenerate widths: all-zero or all-one pattern rotates to itself; step still pulses.

Decomposition:
- Shared header/package: FSM encodings (ST_IDLE = 2'b00, ST_RUN = 2'b01, ST_HOLD = 2'b10), direction constants DIR_LEFT = 0 and DIR_RIGHT = 1, and the default lane width 8.
- One natural sub-module, sc_negedge_detector: a 1-bit falling-edge detector with the same clock/reset, reusable for other active-low game ticks.
- FSM and rotate datapath stay in sc_lane_shifter.

Test Plan:
- Reset, then tick pulses low for 1 cycle → data stays 8'b00110011 (ST_IDLE), step never asserts.
- Load 8'b10000001 with dir = 0, then a 1-cycle tick low → data 8'b00000011 exactly two cycles after the tick edge, step high for exactly one cycle.
- From 8'b00000011 with dir = 1, tick held low for 5 cycles → single rotate to 8'b10000001; second rotate only after tick returns high then low again.
- pause = 1 and three tick falls, then pause = 0 → pattern unchanged and no step during pause; the next fall rotates once.
- load_InLow = 0 with data_InBUS = 8'hF0 in the same cycle as a tick fall → data = 8'hF0, step = 0; next fall with dir = 0 gives 8'hE1.
- Eight consecutive falls, dir = 0, from 8'b00110011 → returns to 8'b00110011 with 8 step pulses. Reset asserted after the 4th step → data 8'b00110011 and state ST_IDLE on the next cycle.

Source files
------------

// File: rtl/sc_lane_shifter_pkg.sv
// Shared encodings for the lane shifter: FSM states, rotate direction, default lane width.
package sc_lane_shifter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_HOLD = 2'b10
    } laneState_t;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    localparam int LANE_WIDTH_DEFAULT = 8;

endpackage

// File: rtl/sc_negedge_detector.sv
// Registered falling-edge detector for active-low game ticks; one pulse per high-to-low transition.
module sc_negedge_detector (
    input  logic clk,
    input  logic rst,
    input  logic sigLow,
    output logic fallPulse
);

    logic sigD;

    // History resets to 0 so a signal already low when reset releases is not an edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            sigD      <= 1'b0;
            fallPulse <= 1'b0;
        end else begin
            sigD      <= sigLow;
            fallPulse <= sigD & ~sigLow;
        end
    end

endmodule

// File: rtl/sc_lane_shifter.sv
// One Frogger lane held in a rotating register; advances one cell per speed-tick falling edge.
module sc_lane_shifter
    import sc_lane_shifter_pkg::*;
#(
    parameter int                               LANESHIFTER_DATAWIDTH = LANE_WIDTH_DEFAULT,
    parameter logic [LANESHIFTER_DATAWIDTH-1:0] LANESHIFTER_INIT      = 8'b00110011
) (
    input  logic                             SC_LANESHIFTER_CLOCK_50,
    input  logic                             SC_LANESHIFTER_RESET_InHigh,
    input  logic                             SC_LANESHIFTER_tick_InLow,
    input  logic                             SC_LANESHIFTER_load_InLow,
    input  logic [LANESHIFTER_DATAWIDTH-1:0] SC_LANESHIFTER_data_InBUS,
    input  logic                             SC_LANESHIFTER_dir_InHigh,
    input  logic                             SC_LANESHIFTER_pause_InHigh,
    output logic [LANESHIFTER_DATAWIDTH-1:0] SC_LANESHIFTER_data_OutBUS,
    output logic                             SC_LANESHIFTER_step_OutHigh
);

    localparam int W = LANESHIFTER_DATAWIDTH;

    laneState_t     state, stateNext;
    logic           tickFall;
    logic           loadEn, rotEn;
    logic [W-1:0]   rotated;

    sc_negedge_detector uTickEdge (
        .clk       (SC_LANESHIFTER_CLOCK_50),
        .rst       (SC_LANESHIFTER_RESET_InHigh),
        .sigLow    (SC_LANESHIFTER_tick_InLow),
        .fallPulse (tickFall)
    );

    assign rotated = (SC_LANESHIFTER_dir_InHigh == DIR_RIGHT)
                   ? {SC_LANESHIFTER_data_OutBUS[0], SC_LANESHIFTER_data_OutBUS[W-1:1]}
                   : {SC_LANESHIFTER_data_OutBUS[W-2:0], SC_LANESHIFTER_data_OutBUS[W-1]};

    // Load outranks pause, pause outranks a tick; ticks seen outside RUN are dropped.
    always_comb begin
        stateNext = state;
        loadEn    = 1'b0;
        rotEn     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!SC_LANESHIFTER_load_InLow) begin
                    loadEn    = 1'b1;
                    stateNext = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!SC_LANESHIFTER_load_InLow)     loadEn    = 1'b1;
                else if (SC_LANESHIFTER_pause_InHigh) stateNext = ST_HOLD;
                else if (tickFall)                  rotEn     = 1'b1;
            end
            ST_HOLD: begin
                if (!SC_LANESHIFTER_load_InLow)      loadEn    = 1'b1;
                else if (!SC_LANESHIFTER_pause_InHigh) stateNext = ST_RUN;
            end
            default: stateNext = ST_IDLE;
        endcase
    end

    always_ff @(posedge SC_LANESHIFTER_CLOCK_50) begin
        if (SC_LANESHIFTER_RESET_InHigh) begin
            state                       <= ST_IDLE;
            SC_LANESHIFTER_data_OutBUS  <= LANESHIFTER_INIT;
            SC_LANESHIFTER_step_OutHigh <= 1'b0;
        end else begin
            state <= stateNext;
            if (loadEn)     SC_LANESHIFTER_data_OutBUS <= SC_LANESHIFTER_data_InBUS;
            else if (rotEn) SC_LANESHIFTER_data_OutBUS <= rotated;
            SC_LANESHIFTER_step_OutHigh <= rotEn;
        end
    end

endmodule

// File: tb/tb_sc_lane_shifter.sv
// Scoreboard bench: stimulus queues expected post-rotate patterns, a negedge monitor checks each step.
module tb_sc_lane_shifter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b1;
    logic       load = 1'b1;
    logic [7:0] dataIn = 8'h00;
    logic       dir = 1'b0;
    logic       pause = 1'b0;
    logic [7:0] dataOut;
    logic       step;

    logic [7:0] expQ[$];
    logic       chkEn = 1'b0;
    logic [7:0] chkData = 8'h00;
    logic       chkStep = 1'b0;
    logic       doneReq = 1'b0;
    string      chkName = "";
    int         vectors = 0;
    int         miscompares = 0;

    always #5 clk = ~clk;

    sc_lane_shifter dut (
        .SC_LANESHIFTER_CLOCK_50     (clk),
        .SC_LANESHIFTER_RESET_InHigh (rst),
        .SC_LANESHIFTER_tick_InLow   (tick),
        .SC_LANESHIFTER_load_InLow   (load),
        .SC_LANESHIFTER_data_InBUS   (dataIn),
        .SC_LANESHIFTER_dir_InHigh   (dir),
        .SC_LANESHIFTER_pause_InHigh (pause),
        .SC_LANESHIFTER_data_OutBUS  (dataOut),
        .SC_LANESHIFTER_step_OutHigh (step)
    );

    // Sole owner of the counters: step pulses, static snapshots and the final drain check.
    always @(negedge clk) begin
        logic [7:0] e;
        if (step) begin
            vectors++;
            if (expQ.size() == 0) begin
                miscompares++;
                $display("FAIL spurious_step: got step with data %02h, no step expected", dataOut);
            end else begin
                e = expQ.pop_front();
                if (dataOut !== e) begin
                    miscompares++;
                    $display("FAIL step_data: got %02h, expected %02h", dataOut, e);
                end
            end
        end
        if (chkEn) begin
            vectors++;
            if (dataOut !== chkData || step !== chkStep) begin
                miscompares++;
                $display("FAIL %s: got data %02h step %0b, expected data %02h step %0b",
                         chkName, dataOut, step, chkData, chkStep);
            end
        end
        if (doneReq) begin
            vectors++;
            if (expQ.size() != 0) begin
                miscompares++;
                $display("FAIL missing_steps: %0d expected steps never seen", expQ.size());
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [7:0] d, input logic s);
        chkName = name; chkData = d; chkStep = s; chkEn = 1'b1;
        cyc(1);
        chkEn = 1'b0;
    endtask

    task automatic pulse(input int lowCycles);
        tick = 1'b0;
        cyc(lowCycles);
        tick = 1'b1;
    endtask

    task automatic loadPat(input logic [7:0] d);
        dataIn = d; load = 1'b0;
        cyc(1);
        load = 1'b1;
    endtask

    initial begin
        logic [7:0] seq[8];
        seq = '{8'h66, 8'hCC, 8'h99, 8'h33, 8'h66, 8'hCC, 8'h99, 8'h33};
        cyc(2);
        check("reset_state", 8'h33, 1'b0);
        rst = 1'b0;
        cyc(1);

        // IDLE ignores ticks
        pulse(1); cyc(3);
        check("idle_tick_ignored", 8'h33, 1'b0);

        // load then one left rotate, two edges after tick drops
        loadPat(8'h81);
        check("load_81", 8'h81, 1'b0);
        dir = 1'b0;
        expQ.push_back(8'h03);
        pulse(1);
        check("before_rotate", 8'h81, 1'b0);
        cyc(1);
        check("step_one_cycle", 8'h03, 1'b0);

        // held-low tick gives a single rotate
        dir = 1'b1;
        expQ.push_back(8'h81);
        pulse(5); cyc(3);
        check("held_tick_single", 8'h81, 1'b0);
        expQ.push_back(8'hC0);
        pulse(1); cyc(3);
        check("second_right", 8'hC0, 1'b0);

        // pause drops ticks
        pause = 1'b1; cyc(1);
        for (int i = 0; i < 3; i++) begin
            pulse(1); cyc(2);
        end
        check("paused_frozen", 8'hC0, 1'b0);
        pause = 1'b0; cyc(1);
        expQ.push_back(8'h60);
        pulse(1); cyc(3);
        check("resume_rotate", 8'h60, 1'b0);

        // load coincident with the registered fall wins
        tick = 1'b0; cyc(1);
        tick = 1'b1; dataIn = 8'hF0; load = 1'b0;
        cyc(1);
        load = 1'b1;
        check("load_beats_tick", 8'hF0, 1'b0);
        dir = 1'b0;
        expQ.push_back(8'hE1);
        pulse(1); cyc(3);
        check("after_load_left", 8'hE1, 1'b0);

        // eight left rotates of INIT return to INIT
        rst = 1'b1; cyc(1); rst = 1'b0;
        loadPat(8'h33);
        for (int i = 0; i < 8; i++) begin
            expQ.push_back(seq[i]);
            pulse(1); cyc(1);
        end
        cyc(3);
        check("full_circle", 8'h33, 1'b0);

        // reset after the fourth step, with an edge pending
        for (int i = 0; i < 4; i++) begin
            expQ.push_back(seq[i]);
            pulse(1); cyc(1);
        end
        rst = 1'b1; tick = 1'b0;
        cyc(1);
        rst = 1'b0;
        check("reset_mid_run", 8'h33, 1'b0);
        tick = 1'b1;
        cyc(3);
        check("pending_edge_lost", 8'h33, 1'b0);
        pulse(1); cyc(3);
        check("idle_after_reset", 8'h33, 1'b0);

        // degenerate patterns rotate to themselves but still step
        loadPat(8'hFF);
        expQ.push_back(8'hFF);
        pulse(1); cyc(3);
        check("all_ones", 8'hFF, 1'b0);
        loadPat(8'h00);
        dir = 1'b1;
        expQ.push_back(8'h00);
        pulse(1); cyc(3);
        check("all_zeros", 8'h00, 1'b0);

        doneReq = 1'b1; cyc(1); doneReq = 1'b0;
        cyc(1);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
